// File: rtl/lifo_ctrl_pkg.sv
// rtl/lifo_ctrl_pkg.sv - shared types for the two-port LIFO controller
package lifo_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/stack_mem_array.sv
// rtl/stack_mem_array.sv - stack storage, one write port and one registered read port
module stack_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset: contents survive rst_n so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lifo_port_arbiter.sv
// rtl/lifo_port_arbiter.sv - round-robin two-port front end for a shared LIFO stack
// Each op runs IDLE -> EXEC -> RESP; guarded ops skip EXEC and report err.
module lifo_port_arbiter
  import lifo_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              busy
);

  localparam logic [ADDR_W:0] SP_FULL = (ADDR_W+1)'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   sp;
  logic              last_gnt;
  logic              gnt_id;
  logic              op_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        elig;
  logic              grant_any;
  logic              grant_id;
  logic              grant_op;
  logic              grant_err;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  assign count = sp;
  assign empty = (sp == '0);
  assign full  = (sp == SP_FULL);

  // A port whose done is still showing is not eligible, so it cannot be re-granted that cycle.
  always_comb begin
    elig      = req & ~done;
    grant_any = |elig;
    grant_id  = (elig == 2'b11) ? ~last_gnt : elig[1];
    grant_op  = grant_id ? op[1] : op[0];
    grant_err = (grant_op == OP_PUSH) ? full : empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          state_nxt = grant_err ? S_RESP : S_EXEC;
        end
      end
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_we    = (state == S_EXEC) && (op_q == OP_PUSH);
    mem_re    = (state == S_EXEC) && (op_q == OP_POP);
    mem_waddr = sp[ADDR_W-1:0];
    mem_raddr = sp[ADDR_W-1:0] - 1'b1;
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp       <= '0;
      last_gnt <= 1'b1;
      gnt_id   <= 1'b0;
      op_q     <= OP_PUSH;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      done     <= 2'b00;
      err      <= 2'b00;
      rdata    <= '0;
    end else begin
      done <= 2'b00;
      err  <= 2'b00;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            gnt_id   <= grant_id;
            op_q     <= grant_op;
            wdata_q  <= grant_id ? wdata1 : wdata0;
            last_gnt <= grant_id;
            err_q    <= grant_err;
          end
        end
        S_EXEC: begin
          sp <= (op_q == OP_PUSH) ? sp + 1'b1 : sp - 1'b1;
        end
        S_RESP: begin
          if ((op_q == OP_POP) && !err_q) begin
            rdata <= mem_rdata;
          end
          done[gnt_id] <= 1'b1;
          err[gnt_id]  <= err_q;
        end
        default: ;
      endcase
    end
  end

  stack_mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(wdata_q),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_lifo_port_arbiter.sv
// tb/tb_lifo_port_arbiter.sv - self-checking bench for lifo_port_arbiter
module tb_lifo_port_arbiter;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] op = 2'b00;
  logic [7:0] wdata0 = 8'h00;
  logic [7:0] wdata1 = 8'h00;
  logic [1:0] done;
  logic [1:0] err;
  logic [7:0] rdata;
  logic [8:0] count;
  logic       empty;
  logic       full;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a plain queue as the stack, the held pop value, and the port served last.
  logic [7:0] stk[$];
  logic [7:0] m_rdata = 8'h00;
  int         m_last  = 1;

  always #5 clk = ~clk;

  lifo_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .op    (op),
    .wdata0(wdata0),
    .wdata1(wdata1),
    .done  (done),
    .err   (err),
    .rdata (rdata),
    .count (count),
    .empty (empty),
    .full  (full),
    .busy  (busy)
  );

  function automatic bit model_apply(input bit is_pop, input logic [7:0] d);
    if (!is_pop) begin
      if (stk.size() == DEPTH) return 1'b1;
      stk.push_back(d);
      return 1'b0;
    end
    if (stk.size() == 0) return 1'b1;
    m_rdata = stk.pop_back();
    return 1'b0;
  endfunction

  task automatic do_op(input int p, input bit is_pop, input logic [7:0] d, input string tag);
    bit exp_err;
    bit seen;
    int cyc;
    req[p] = 1'b1;
    op[p]  = is_pop;
    if (p == 0) wdata0 = d; else wdata1 = d;
    exp_err = model_apply(is_pop, d);
    m_last  = p;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done[p]) seen = 1'b1;
    end
    req[p] = 1'b0;
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no done[%0d] within %0d cycles", tag, p, cyc);
    end else begin
      n_tests += 6;
      if (cyc !== (exp_err ? 2 : 3)) begin
        n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, exp_err ? 2 : 3);
      end
      if (err[p] !== exp_err || done[1-p] !== 1'b0) begin
        n_fail++; $display("FAIL %s err/done: got err=%b done=%b want err[%0d]=%b", tag, err, done, p, exp_err);
      end
      if (rdata !== m_rdata) begin
        n_fail++; $display("FAIL %s rdata: got %02h want %02h", tag, rdata, m_rdata);
      end
      if (count !== 9'(stk.size())) begin
        n_fail++; $display("FAIL %s count: got %0d want %0d", tag, count, stk.size());
      end
      if (empty !== (stk.size() == 0)) begin
        n_fail++; $display("FAIL %s empty: got %b want %b", tag, empty, stk.size() == 0);
      end
      if (full !== (stk.size() == DEPTH)) begin
        n_fail++; $display("FAIL %s full: got %b want %b", tag, full, stk.size() == DEPTH);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (done !== 2'b00 || err !== 2'b00 || rdata !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got done=%b err=%b rdata=%02h busy=%b want 0", done, err, rdata, busy);
    end
    n_tests++;
    if (count !== 9'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL reset_level: got count=%0d empty=%b full=%b want 0/1/0", count, empty, full);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_push_pop();
    do_op(0, 1'b0, 8'hA5, "push_a5");
    do_op(1, 1'b1, 8'h00, "pop_a5");
  endtask

  task automatic test_tie(input bit o0, input bit o1, input logic [7:0] d0, input logic [7:0] d1, input string tag);
    int first;
    int expp;
    int got;
    int cyc;
    bit e;
    first  = (m_last == 0) ? 1 : 0;
    req    = 2'b11;
    op     = {o1, o0};
    wdata0 = d0;
    wdata1 = d1;
    got = 0;
    cyc = 0;
    while (got < 2 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done != 2'b00) begin
        expp = (got == 0) ? first : 1 - first;
        e = model_apply(expp == 1 ? o1 : o0, expp == 1 ? d1 : d0);
        m_last = expp;
        n_tests += 3;
        if (done[expp] !== 1'b1 || done[1-expp] !== 1'b0) begin
          n_fail++; $display("FAIL %s order%0d: got done=%b want port %0d", tag, got, done, expp);
        end
        if (err[expp] !== e) begin
          n_fail++; $display("FAIL %s err%0d: got %b want %b", tag, got, err[expp], e);
        end
        if (rdata !== m_rdata || count !== 9'(stk.size())) begin
          n_fail++; $display("FAIL %s data%0d: got rdata=%02h count=%0d want %02h/%0d", tag, got, rdata, count, m_rdata, stk.size());
        end
        req = req & ~done;
        got++;
      end
    end
    req = 2'b00;
    if (got < 2) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: got %0d dones want 2", tag, got);
    end
    @(negedge clk);
  endtask

  task automatic test_pop_empty();
    do_op(0, 1'b1, 8'h00, "pop_empty");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      do_op($urandom_range(0, 1), ($urandom_range(0, 2) == 0), 8'($urandom), "random");
    end
  endtask

  task automatic test_fill();
    while (stk.size() > 0) do_op(1, 1'b1, 8'h00, "drain");
    for (int i = 0; i < DEPTH; i++) do_op(0, 1'b0, 8'(i), "fill");
    n_tests++;
    if (full !== 1'b1 || count !== 9'd256) begin
      n_fail++; $display("FAIL fill_full: got full=%b count=%0d want 1/256", full, count);
    end
    do_op(1, 1'b0, 8'h77, "push_full");
    do_op(0, 1'b1, 8'h00, "pop_ff");
    n_tests++;
    if (rdata !== 8'hFF) begin
      n_fail++; $display("FAIL pop_ff_value: got %02h want ff", rdata);
    end
  endtask

  task automatic test_reset_mid_op();
    int spurious;
    req[0] = 1'b1;
    op[0]  = 1'b0;
    wdata0 = 8'h3C;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy: got %b want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || count !== 9'd0 || empty !== 1'b1 || done !== 2'b00 || rdata !== 8'h00) begin
      n_fail++; $display("FAIL mid_async: got busy=%b count=%0d empty=%b done=%b rdata=%02h want 0/0/1/00/00", busy, count, empty, done, rdata);
    end
    req = 2'b00;
    stk.delete();
    m_rdata = 8'h00;
    m_last  = 1;
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (5) begin
      @(negedge clk);
      if (done != 2'b00) spurious++;
    end
    n_tests++;
    if (spurious != 0) begin
      n_fail++; $display("FAIL mid_no_done: got %0d done cycles want 0", spurious);
    end
    do_op(0, 1'b0, 8'h96, "post_reset_push");
    do_op(1, 1'b1, 8'h00, "post_reset_pop");
  endtask

  task automatic test_back_to_back();
    int t[3];
    int got;
    int cyc;
    req[0] = 1'b1;
    op[0]  = 1'b0;
    wdata0 = 8'h5C;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done[0]) begin
        t[got] = cyc;
        void'(model_apply(1'b0, 8'h5C));
        got++;
        if (got == 3) req[0] = 1'b0;
      end
    end
    req[0] = 1'b0;
    m_last = 0;
    n_tests++;
    if (got != 3) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d dones want 3", got);
    end else begin
      n_tests += 3;
      if (t[0] != 3) begin
        n_fail++; $display("FAIL b2b_first: got %0d want 3", t[0]);
      end
      if (t[1] - t[0] != 4 || t[2] - t[1] != 4) begin
        n_fail++; $display("FAIL b2b_interval: got %0d,%0d want 4,4", t[1] - t[0], t[2] - t[1]);
      end
      if (count !== 9'(stk.size()) || err !== 2'b00) begin
        n_fail++; $display("FAIL b2b_count: got count=%0d err=%b want %0d/00", count, err, stk.size());
      end
    end
    @(negedge clk);
    do_op(1, 1'b1, 8'h00, "b2b_pop");
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_tie(1'b0, 1'b0, 8'h11, 8'h22, "tie_push");
    test_tie(1'b1, 1'b1, 8'h00, 8'h00, "tie_pop");
    test_pop_empty();
    test_random();
    test_fill();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
